// File: rtl/fetch_ifid.sv
// fetch_ifid: PC owner, I-mem request, and IF/ID register with a
// one-entry hold buffer, downstream redirect flush, and sticky halt.
//
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   ihit, imemload            I-cache hit and word for imemaddr
//   stall_i                   hold IF/ID contents
//   redirect_i, redirect_pc_i taken branch/jump and its target
//   halt_i                    freeze fetch until reset
//   iREN, imemaddr            fetch request (imemaddr = PC)
//   instr_out, pcplus4_out    IF/ID instruction and its PC+4
//   valid_out                 IF/ID holds a real instruction
//   halted_out                fetch frozen
module fetch_ifid #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] pcplus4_out,
  output logic        valid_out,
  output logic        halted_out
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      st_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] buf_q;
  logic [31:0] bufpc4_q;

  logic [31:0] pc4_d;
  logic [31:0] redir_d;
  logic        unused_rpc;

  // Modulo-2^32: FFFF_FFFC + 4 wraps to 0.
  assign pc4_d      = pc_q + 32'd4;
  assign redir_d    = {redirect_pc_i[31:2], 2'b00};
  assign unused_rpc = ^redirect_pc_i[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q     <= FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      buf_q    <= '0;
      bufpc4_q <= '0;
    end else if (halt_i || st_q == HALTED) begin
      // Sticky: once halted only nRST leaves.
      st_q    <= HALTED;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (redirect_i) begin
      // Flush wins over stall; any hit is wrong-path.
      st_q     <= FETCH;
      pc_q     <= redir_d;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      buf_q    <= '0;
      bufpc4_q <= '0;
    end else if (st_q == HOLD) begin
      if (!stall_i) begin
        st_q    <= FETCH;
        instr_q <= buf_q;
        pc4_q   <= bufpc4_q;
        valid_q <= 1'b1;
      end
    end else if (stall_i) begin
      // Park a hit so the stall cannot drop it.
      if (ihit) begin
        st_q     <= HOLD;
        buf_q    <= imemload;
        bufpc4_q <= pc4_d;
        pc_q     <= pc4_d;
      end
    end else if (ihit) begin
      instr_q <= imemload;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
      pc_q    <= pc4_d;
    end else begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end
  end

  assign iREN        = (st_q == FETCH);
  assign halted_out  = (st_q == HALTED);
  assign imemaddr    = pc_q;
  assign instr_out   = instr_q;
  assign pcplus4_out = pc4_q;
  assign valid_out   = valid_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// tb_fetch_ifid: scoreboard bench for fetch_ifid, two instances
// (PC_INIT 0 and FFFF_FFFC) driven with directed + random stimulus.
module tb_fetch_ifid;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;

  logic        ren[2];
  logic [31:0] addr[2];
  logic [31:0] ins[2];
  logic [31:0] p4[2];
  logic        vld[2];
  logic        hlt[2];

  always #5 CLK = ~CLK;

  fetch_ifid #(.PC_INIT(32'h0000_0000)) dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .iREN(ren[0]), .imemaddr(addr[0]), .instr_out(ins[0]),
    .pcplus4_out(p4[0]), .valid_out(vld[0]), .halted_out(hlt[0])
  );

  fetch_ifid #(.PC_INIT(32'hFFFF_FFFC)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .iREN(ren[1]), .imemaddr(addr[1]), .instr_out(ins[1]),
    .pcplus4_out(p4[1]), .valid_out(vld[1]), .halted_out(hlt[1])
  );

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        vld;
    logic        hlt;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;

  // Reference model: an architectural PC, a queue of fetched-but-
  // not-yet-delivered words, the visible IF/ID word, and a halt flag.
  logic [31:0] m_pc[2];
  logic [31:0] m_ins[2];
  logic [31:0] m_p4[2];
  logic        m_vld[2];
  bit          m_halt[2];
  logic [63:0] m_pend0[$];
  logic [63:0] m_pend1[$];
  int          halt_age = 0;

  localparam logic [31:0] INIT0 = 32'h0000_0000;
  localparam logic [31:0] INIT1 = 32'hFFFF_FFFC;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
  endfunction

  function automatic int npend(input int k);
    return (k == 0) ? m_pend0.size() : m_pend1.size();
  endfunction

  task automatic bubble(input int k);
    m_ins[k] = '0;
    m_p4[k]  = '0;
    m_vld[k] = 1'b0;
  endtask

  task automatic m_reset();
    m_pc[0] = INIT0;
    m_pc[1] = INIT1;
    for (int k = 0; k < 2; k++) begin
      bubble(k);
      m_halt[k] = 1'b0;
    end
    m_pend0.delete();
    m_pend1.delete();
  endtask

  task automatic m_step(input int k);
    logic [63:0] w;
    if (m_halt[k] || halt_i) begin
      m_halt[k] = 1'b1;
      bubble(k);
    end else if (redirect_i) begin
      m_pc[k] = redirect_pc_i & ~32'd3;
      bubble(k);
      if (k == 0) m_pend0.delete();
      else m_pend1.delete();
    end else if (npend(k) != 0) begin
      if (!stall_i) begin
        w = (k == 0) ? m_pend0.pop_front() : m_pend1.pop_front();
        m_ins[k] = w[63:32];
        m_p4[k]  = w[31:0];
        m_vld[k] = 1'b1;
      end
    end else if (ihit) begin
      m_pc[k] = m_pc[k] + 32'd4;
      if (stall_i) begin
        w = {imemload, m_pc[k]};
        if (k == 0) m_pend0.push_back(w);
        else m_pend1.push_back(w);
      end else begin
        m_ins[k] = imemload;
        m_p4[k]  = m_pc[k];
        m_vld[k] = 1'b1;
      end
    end else if (!stall_i) begin
      bubble(k);
    end
  endtask

  function automatic exp_t m_out(input int k);
    exp_t e;
    e.ren  = !m_halt[k] && npend(k) == 0;
    e.addr = m_pc[k];
    e.ins  = m_ins[k];
    e.p4   = m_p4[k];
    e.vld  = m_vld[k];
    e.hlt  = m_halt[k];
    return e;
  endfunction

  task automatic push_exp();
    sb0.push_back(m_out(0));
    sb1.push_back(m_out(1));
  endtask

  // Called at posedge+1; inputs here are used by the next edge.
  task automatic cyc(input bit h, input bit r, input logic [31:0] rpc,
                     input bit s, input bit ih);
    halt_i        = h;
    redirect_i    = r;
    redirect_pc_i = rpc;
    stall_i       = s;
    ihit          = ih;
    imemload      = memw(m_pc[0]);
    @(posedge CLK);
    m_step(0);
    m_step(1);
    #1;
    push_exp();
    halt_age = m_halt[0] ? halt_age + 1 : 0;
  endtask

  task automatic do_reset();
    ihit = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    nRST = 1'b0;
    m_reset();
    #1;
    push_exp();
    @(negedge CLK);
    #2;
    nRST = 1'b1;
    halt_age = 0;
  endtask

  task automatic rnd_cyc();
    bit h, r, s, ih;
    logic [31:0] t;
    h  = ($urandom_range(0, 63) == 0);
    r  = ($urandom_range(0, 9) == 0);
    s  = ($urandom_range(0, 3) == 0);
    ih = ($urandom_range(0, 3) != 0);
    t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    cyc(h, r, t, s, ih);
  endtask

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic chk_all(input int k, input exp_t e);
    chk("iREN", k, {31'b0, ren[k]}, {31'b0, e.ren});
    chk("imemaddr", k, addr[k], e.addr);
    chk("instr_out", k, ins[k], e.ins);
    chk("pcplus4_out", k, p4[k], e.p4);
    chk("valid_out", k, {31'b0, vld[k]}, {31'b0, e.vld});
    chk("halted_out", k, {31'b0, hlt[k]}, {31'b0, e.hlt});
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (sb0.size() != 0) chk_all(0, sb0.pop_front());
      if (sb1.size() != 0) chk_all(1, sb1.pop_front());
    end
  end

  initial begin
    @(posedge CLK);
    #1;
    do_reset();
    // Straight-line fetch, one per cycle.
    repeat (4) cyc(0, 0, 0, 0, 1);
    // Miss pattern.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    // Hit under stall, hold for 3 cycles, release.
    repeat (3) cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Redirect from HOLD while still stalled.
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 32'h0000_0103, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);
    // Halt beats redirect and hit.
    cyc(1, 1, 32'h0000_0200, 0, 1);
    repeat (10) rnd_cyc();
    @(posedge CLK);
    #1;
    do_reset();
    repeat (2) cyc(0, 0, 0, 0, 1);
    // Redirect to the top word to exercise wrap on dut0.
    cyc(0, 1, 32'hFFFF_FFFE, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if (halt_age >= 10) begin
        @(posedge CLK);
        #1;
        do_reset();
      end else begin
        rnd_cyc();
      end
    end
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: left %0d/%0d expected 0",
               sb0.size(), sb1.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction fetch stage fused with the IF/ID pipeline register: owns the PC, drives the instruction-memory request, and presents one registered instruction per cycle to decode, the stage that feeds the ID/EX latch. It handles cache-miss bubbles and hazard stalls, using a one-entry hold buffer so a hit arriving during a stall is never lost. It also handles branch/jump redirects resolved downstream, which flush IF/ID, and halt, which freezes fetch until reset.

## Interface
- PC_INIT, 32'h0000_0000, reset value of PC
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction cache hit; imemload valid for current imemaddr this cycle
- imemload  in  32  instruction word from cache
- stall_i  in  1  hold IF/ID contents (load-use hazard or data-cache wait)
- redirect_i  in  1  taken branch/jump/JR resolved downstream
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored, forced to 00
- halt_i  in  1  halt instruction committed; stop fetching
- iREN  out  1  instruction read enable
- imemaddr  out  32  fetch address (= PC)
- instr_out  out  32  IF/ID instruction
- pcplus4_out  out  32  IF/ID PC+4 of instr_out
- valid_out  out  1  IF/ID holds a real instruction (0 = bubble)
- halted_out  out  1  fetch frozen

## Operation
- States: FETCH, HOLD, HALTED. Reset → FETCH.
- Per-cycle priority: halt_i > redirect_i > stall_i > ihit > miss.
- FETCH: iREN=1, imemaddr=PC.
  - ihit & !stall_i: IF/ID ← {imemload, PC+4, valid=1}; PC ← PC+4.
  - ihit & stall_i: buf ← imemload, bufpc4 ← PC+4; PC ← PC+4; IF/ID held; → HOLD.
  - !ihit & !stall_i: IF/ID ← bubble (instr 0, pcplus4 0, valid 0); PC held.
  - !ihit & stall_i: everything held.
- HOLD: iREN=0, imemaddr=PC.
  - stall_i: held.
  - !stall_i: IF/ID ← {buf, bufpc4, 1}; → FETCH.
- Redirect in FETCH or HOLD:
  - PC ← {redirect_pc_i[31:2], 2'b00}.
  - IF/ID ← bubble, even if stall_i is asserted.
  - Buffer discarded; → FETCH.
  - Any same-cycle ihit is ignored.
- Halt in any state:
  - → HALTED; IF/ID ← bubble; PC held.
  - iREN=0, halted_out=1.
  - Only nRST exits HALTED; redirect_i, stall_i and ihit are ignored there.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset (asynchronous, immediate):
  - PC=PC_INIT; state FETCH, so iREN=1 and imemaddr=PC_INIT while in reset and after.
  - instr_out=0, pcplus4_out=0, valid_out=0, halted_out=0; buffer cleared.
- Latency: ihit in cycle n → instr_out and valid_out updated at edge ending n, visible in n+1.
- Throughput: 1 instruction/cycle with ihit held high and no stall.
- iREN and halted_out are combinational from state only; no combinational path from inputs to outputs.
- Redirect at cycle n: imemaddr = target in n+1; valid_out=0 in n+1. The first target instruction appears in n+2 at the earliest.
- Reset asserted mid-HOLD or HALTED: returns to FETCH at PC_INIT; buffered instruction is lost.
- Stall deasserting in the same cycle a HOLD→FETCH release happens: the new fetch starts the following cycle; no instruction is duplicated or skipped.

## Test plan
- Reset, then ihit=1 each cycle with imemload = address-tagged words: imemaddr steps 0,4,8,C. instr_out lags by one cycle. pcplus4_out = 4,8,C,10. valid_out=1 from cycle 2.
- Miss pattern ihit 1,0,0,1 at PC 0,4,4,4: valid_out sequence 1,0,0,1. The second valid instr is the word at 4, with pcplus4_out=8.
- ihit=1 with stall_i=1 for 3 cycles at PC=8:
  - Enters HOLD; iREN=0 for cycles 2–3.
  - IF/ID unchanged during the stall.
  - On release, instr_out = word@8 and pcplus4_out=0xC.
  - Next fetch is from 0xC.
- redirect_i=1, redirect_pc_i=0x0000_0103 while in HOLD with stall_i=1:
  - Next cycle imemaddr=0x100, valid_out=0, state FETCH.
  - The buffered word is never presented.
- halt_i=1 together with redirect_i=1 and ihit=1: halted_out=1, iREN=0, valid_out=0, PC unchanged. Remains so for 10 cycles of random inputs; nRST pulse restores imemaddr=PC_INIT.
- PC_INIT=32'hFFFF_FFFC with ihit=1: next imemaddr=0. pcplus4_out=0 for that instruction.
